// File: rtl/pr_bus_pkg.sv
// pr_bus_pkg: shared FSM states, master ids, default timer bases and address decode for the bus arbiter
package pr_bus_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;
  localparam logic [31:0] TIMER0_BASE_DEF = 32'h0000_7F00;
  localparam logic [31:0] TIMER1_BASE_DEF = 32'h0000_7F10;
  function automatic logic [1:0] decode_hit(input logic [31:0] addr, input logic [31:0] t0, input logic [31:0] t1);
    return (addr[31:4] == t0[31:4]) ? 2'b01 : (addr[31:4] == t1[31:4]) ? 2'b10 : 2'b00;
  endfunction
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter; a tie goes to the master not granted last
module rr_arb2
  import pr_bus_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       take,
  output logic [1:0] gnt
);
  logic last;
  logic win;
  always_comb begin
    win = (req[0] & req[1]) ? ~last : req[1];
    gnt = (|req) ? (win ? 2'b10 : 2'b01) : 2'b00;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) last <= M1;
    else if (take && |req) last <= win;
endmodule

// File: rtl/pr_bus_arbiter.sv
// pr_bus_arbiter: arbitrates two masters onto two timer devices with a 3-cycle access FSM and registered interrupt pending
module pr_bus_arbiter
  import pr_bus_pkg::*;
#(
  parameter logic [31:0] TIMER0_BASE = TIMER0_BASE_DEF,
  parameter logic [31:0] TIMER1_BASE = TIMER1_BASE_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         m0_req,
  input  logic         m0_we,
  input  logic [31:0]  m0_addr,
  input  logic [31:0]  m0_wd,
  output logic         m0_done,
  output logic [31:0]  m0_rd,
  output logic         m0_err,
  input  logic         m1_req,
  input  logic         m1_we,
  input  logic [31:0]  m1_addr,
  input  logic [31:0]  m1_wd,
  output logic         m1_done,
  output logic [31:0]  m1_rd,
  output logic         m1_err,
  output logic [1:0]   dev_sel,
  output logic         dev_we,
  output logic [1:0]   dev_addr,
  output logic [31:0]  dev_wd,
  input  logic [31:0]  dev_rd0,
  input  logic [31:0]  dev_rd1,
  input  logic [1:0]   irq_dev,
  output logic [15:10] Pr_IP
);
  state_t      state, state_nx;
  logic [1:0]  gnt;
  logic        win_q, we_q, err_q;
  logic [1:0]  sel_q, idx_q;
  logic [31:0] wd_q, rd_q;
  logic [31:0] addr_c;
  logic [1:0]  hit_c;
  logic        err_c, acc, resp;
  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   ({m1_req, m0_req}),
    .take  (state == IDLE),
    .gnt   (gnt)
  );
  always_comb begin
    addr_c   = gnt[1] ? m1_addr : m0_addr;
    hit_c    = decode_hit(addr_c, TIMER0_BASE, TIMER1_BASE);
    err_c    = (hit_c == 2'b00) || (addr_c[1:0] != 2'b00) || (addr_c[3:2] == 2'b11);
    state_nx = (state == IDLE) ? ((|gnt) ? ACCESS : IDLE) : (state == ACCESS) ? RESP : IDLE;
    acc      = (state == ACCESS) && !err_q;
    resp     = (state == RESP);
    dev_sel  = acc ? sel_q : 2'b00;
    dev_we   = acc & we_q;
    dev_addr = (state == ACCESS) ? idx_q : 2'b00;
    dev_wd   = (state == ACCESS) ? wd_q : 32'h0;
    m0_done  = resp & (win_q == M0);
    m1_done  = resp & (win_q == M1);
    m0_rd    = m0_done ? rd_q : 32'h0;
    m1_rd    = m1_done ? rd_q : 32'h0;
    m0_err   = m0_done & err_q;
    m1_err   = m1_done & err_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  // request fields are only sampled in IDLE, so later req changes have no effect
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      win_q <= M0;
      we_q  <= 1'b0;
      err_q <= 1'b0;
      sel_q <= 2'b00;
      idx_q <= 2'b00;
      wd_q  <= 32'h0;
      rd_q  <= 32'h0;
    end else if (state == IDLE && |gnt) begin
      win_q <= gnt[1];
      we_q  <= gnt[1] ? m1_we : m0_we;
      wd_q  <= gnt[1] ? m1_wd : m0_wd;
      idx_q <= addr_c[3:2];
      sel_q <= hit_c;
      err_q <= err_c;
    end else if (state == ACCESS) begin
      rd_q <= (!we_q && !err_q) ? (sel_q[0] ? dev_rd0 : dev_rd1) : 32'h0;
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) Pr_IP <= 6'b0;
    else Pr_IP <= {4'b0000, irq_dev};
endmodule

// File: tb/tb_pr_bus_arbiter.sv
// tb_pr_bus_arbiter: directed and randomized checks of pr_bus_arbiter against a transaction-level model
module tb_pr_bus_arbiter;
  logic clk = 1'b0, reset = 1'b1;
  logic m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [31:0] m0_addr = 0, m0_wd = 0, m1_addr = 0, m1_wd = 0;
  logic m0_done, m1_done, m0_err, m1_err, dev_we;
  logic [31:0] m0_rd, m1_rd, dev_wd;
  logic [1:0] dev_sel, dev_addr;
  logic [31:0] dev_rd0 = 0, dev_rd1 = 0;
  logic [1:0] irq_dev = 0;
  logic [15:10] Pr_IP;
  int errors = 0, checks = 0;
  logic last_m = 1'b1;
  localparam logic [31:0] T0 = 32'h0000_7F00;
  localparam logic [31:0] T1 = 32'h0000_7F10;
  pr_bus_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wd(m0_wd),
    .m0_done(m0_done), .m0_rd(m0_rd), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wd(m1_wd),
    .m1_done(m1_done), .m1_rd(m1_rd), .m1_err(m1_err),
    .dev_sel(dev_sel), .dev_we(dev_we), .dev_addr(dev_addr), .dev_wd(dev_wd),
    .dev_rd0(dev_rd0), .dev_rd1(dev_rd1), .irq_dev(irq_dev), .Pr_IP(Pr_IP)
  );
  always #5 clk = ~clk;
  function automatic logic [1:0] exp_sel(input logic [31:0] a);
    if (a % 4 != 0) return 2'b00;
    if (a >= T0 && a < T0 + 12) return 2'b01;
    if (a >= T1 && a < T1 + 12) return 2'b10;
    return 2'b00;
  endfunction
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    m0_req = 0; m1_req = 0;
    @(negedge clk);
    reset = 1'b0;
    last_m = 1'b1;
  endtask
  task automatic test_reset();
    irq_dev = 2'b11;
    @(negedge clk);
    @(negedge clk);
    checks++; if (dev_sel !== 2'b00) begin errors++; $display("FAIL rst_sel got %b want 00", dev_sel); end
    checks++; if ({m1_done, m0_done} !== 2'b00) begin errors++; $display("FAIL rst_done got %b want 00", {m1_done, m0_done}); end
    checks++; if (Pr_IP !== 6'b0) begin errors++; $display("FAIL rst_pr_ip got %b want 000000", Pr_IP); end
    irq_dev = 2'b00;
    reset = 1'b0;
  endtask
  task automatic test_single_read();
    m0_req = 1; m0_we = 0; m0_addr = 32'h7F04; dev_rd0 = 32'h1234;
    @(negedge clk);
    checks++; if (dev_sel !== 2'b01) begin errors++; $display("FAIL sr_sel got %b want 01", dev_sel); end
    checks++; if (dev_addr !== 2'd1) begin errors++; $display("FAIL sr_addr got %0d want 1", dev_addr); end
    checks++; if (dev_we !== 1'b0) begin errors++; $display("FAIL sr_we got %b want 0", dev_we); end
    @(negedge clk);
    checks++; if (m0_done !== 1'b1 || m1_done !== 1'b0) begin errors++; $display("FAIL sr_done got %b%b want 01", m1_done, m0_done); end
    checks++; if (m0_rd !== 32'h1234) begin errors++; $display("FAIL sr_rd got %h want 00001234", m0_rd); end
    checks++; if (m0_err !== 1'b0) begin errors++; $display("FAIL sr_err got %b want 0", m0_err); end
    m0_req = 0;
    @(negedge clk);
    checks++; if (m0_done !== 1'b0) begin errors++; $display("FAIL sr_done_pulse got %b want 0", m0_done); end
    last_m = 1'b0;
  endtask
  task automatic test_tie();
    do_reset();
    m0_req = 1; m0_we = 0; m0_addr = T0; dev_rd0 = 32'h11;
    m1_req = 1; m1_we = 0; m1_addr = T1; dev_rd1 = 32'h22;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (dev_sel !== (i % 2 ? 2'b10 : 2'b01)) begin errors++; $display("FAIL tie_sel%0d got %b want %b", i, dev_sel, (i % 2 ? 2'b10 : 2'b01)); end
      @(negedge clk);
      checks++; if ({m1_done, m0_done} !== (i % 2 ? 2'b10 : 2'b01)) begin errors++; $display("FAIL tie_done%0d got %b", i, {m1_done, m0_done}); end
      checks++; if ((i % 2 ? m1_rd : m0_rd) !== (i % 2 ? 32'h22 : 32'h11)) begin errors++; $display("FAIL tie_rd%0d got %h/%h", i, m0_rd, m1_rd); end
      @(negedge clk);
    end
    m0_req = 0; m1_req = 0;
    last_m = 1'b0;
  endtask
  task automatic test_write();
    m1_req = 1; m1_we = 1; m1_addr = 32'h7F18; m1_wd = 32'hA5A5_A5A5; dev_rd1 = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++; if (dev_sel !== 2'b10 || dev_we !== 1'b1) begin errors++; $display("FAIL wr_strobe got sel=%b we=%b want 10/1", dev_sel, dev_we); end
    checks++; if (dev_addr !== 2'd2 || dev_wd !== 32'hA5A5_A5A5) begin errors++; $display("FAIL wr_bus got addr=%0d wd=%h", dev_addr, dev_wd); end
    @(negedge clk);
    checks++; if (dev_sel !== 2'b00 || dev_we !== 1'b0) begin errors++; $display("FAIL wr_one_cycle got sel=%b we=%b want 00/0", dev_sel, dev_we); end
    checks++; if (m1_done !== 1'b1 || m1_rd !== 32'h0 || m1_err !== 1'b0) begin errors++; $display("FAIL wr_resp got done=%b rd=%h err=%b", m1_done, m1_rd, m1_err); end
    m1_req = 0; m1_we = 0;
    @(negedge clk);
    last_m = 1'b1;
  endtask
  task automatic test_errors();
    logic [31:0] bad [3] = '{32'h7F0C, 32'h7F02, 32'h8000};
    for (int i = 0; i < 3; i++) begin
      m0_req = 1; m0_we = 0; m0_addr = bad[i]; dev_rd0 = 32'hFFFF_FFFF; dev_rd1 = 32'hFFFF_FFFF;
      @(negedge clk);
      checks++; if (dev_sel !== 2'b00 || dev_we !== 1'b0) begin errors++; $display("FAIL err_strobe%0d got sel=%b we=%b", i, dev_sel, dev_we); end
      @(negedge clk);
      checks++; if (m0_done !== 1'b1 || m0_err !== 1'b1 || m0_rd !== 32'h0) begin errors++; $display("FAIL err_resp%0d got done=%b err=%b rd=%h", i, m0_done, m0_err, m0_rd); end
      checks++; if (dev_sel !== 2'b00) begin errors++; $display("FAIL err_resp_sel%0d got %b", i, dev_sel); end
      m0_req = 0;
      @(negedge clk);
    end
    last_m = 1'b0;
  endtask
  task automatic test_reset_mid();
    do_reset();
    m0_req = 1; m0_we = 0; m0_addr = 32'h7F04;
    @(negedge clk);
    checks++; if (dev_sel !== 2'b01) begin errors++; $display("FAIL rm_pre got %b want 01", dev_sel); end
    #2 reset = 1'b1;
    #1;
    checks++; if (dev_sel !== 2'b00) begin errors++; $display("FAIL rm_async got %b want 00", dev_sel); end
    @(negedge clk);
    checks++; if ({m1_done, m0_done} !== 2'b00) begin errors++; $display("FAIL rm_no_done got %b want 00", {m1_done, m0_done}); end
    reset = 1'b0; m0_req = 0;
    m1_req = 1; m1_we = 0; m1_addr = 32'h7F14; dev_rd1 = 32'h5555;
    @(negedge clk);
    checks++; if (dev_sel !== 2'b10 || dev_addr !== 2'd1) begin errors++; $display("FAIL rm_m1_strobe got sel=%b addr=%0d", dev_sel, dev_addr); end
    @(negedge clk);
    checks++; if (m1_done !== 1'b1 || m1_rd !== 32'h5555 || m0_done !== 1'b0) begin errors++; $display("FAIL rm_m1_done got done=%b rd=%h", m1_done, m1_rd); end
    m1_req = 0;
    @(negedge clk);
    last_m = 1'b1;
  endtask
  task automatic test_irq();
    m0_req = 1; m0_we = 0; m0_addr = T0; irq_dev = 2'b10;
    #1;
    checks++; if (Pr_IP !== 6'b000000) begin errors++; $display("FAIL irq_delay got %b want 000000", Pr_IP); end
    @(negedge clk);
    checks++; if (Pr_IP !== 6'b000010) begin errors++; $display("FAIL irq_10 got %b want 000010", Pr_IP); end
    irq_dev = 2'b01;
    @(negedge clk);
    checks++; if (Pr_IP !== 6'b000001) begin errors++; $display("FAIL irq_01 got %b want 000001", Pr_IP); end
    m0_req = 0; irq_dev = 2'b00;
    @(negedge clk);
    checks++; if (Pr_IP !== 6'b000000) begin errors++; $display("FAIL irq_00 got %b want 000000", Pr_IP); end
    last_m = 1'b0;
  endtask
  task automatic test_random();
    logic        pend [2];
    logic        we   [2];
    logic [31:0] ad   [2];
    logic [31:0] wd   [2];
    logic        w;
    logic [1:0]  es;
    logic [31:0] erd;
    do_reset();
    pend = '{1'b0, 1'b0};
    for (int n = 0; n < 60; n++) begin
      for (int m = 0; m < 2; m++)
        if (!pend[m] && ($urandom_range(0, 1) == 1 || (m == 1 && !pend[0]))) begin
          pend[m] = 1'b1;
          we[m] = 1'($urandom_range(0, 1));
          wd[m] = $urandom;
          case ($urandom_range(0, 3))
            0: ad[m] = T0;
            1: ad[m] = T1;
            2: ad[m] = 32'h8000;
            default: ad[m] = $urandom & 32'hFFFF_FFF0;
          endcase
          ad[m] = ad[m] + $urandom_range(0, 3) * 4 + ($urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0);
        end
      m0_req = pend[0]; m0_we = we[0]; m0_addr = ad[0]; m0_wd = wd[0];
      m1_req = pend[1]; m1_we = we[1]; m1_addr = ad[1]; m1_wd = wd[1];
      if (pend[0] && pend[1]) w = ~last_m;
      else w = pend[1];
      es = exp_sel(ad[w]);
      @(negedge clk);
      dev_rd0 = $urandom; dev_rd1 = $urandom;
      checks++; if (dev_sel !== es || dev_we !== (es != 0 && we[w])) begin errors++; $display("FAIL rnd_strobe%0d got sel=%b we=%b want %b/%b", n, dev_sel, dev_we, es, (es != 0 && we[w])); end
      if (es != 0) begin
        checks++; if (dev_addr !== 2'((ad[w] - (es[0] ? T0 : T1)) / 4) || dev_wd !== wd[w]) begin errors++; $display("FAIL rnd_bus%0d got addr=%0d wd=%h", n, dev_addr, dev_wd); end
      end
      erd = (es != 0 && !we[w]) ? (es[0] ? dev_rd0 : dev_rd1) : 32'h0;
      @(negedge clk);
      checks++; if ({m1_done, m0_done} !== (w ? 2'b10 : 2'b01)) begin errors++; $display("FAIL rnd_done%0d got %b want %b", n, {m1_done, m0_done}, (w ? 2'b10 : 2'b01)); end
      checks++; if ((w ? m1_rd : m0_rd) !== erd || (w ? m0_rd : m1_rd) !== 32'h0) begin errors++; $display("FAIL rnd_rd%0d got m0=%h m1=%h want %h", n, m0_rd, m1_rd, erd); end
      checks++; if ((w ? m1_err : m0_err) !== (es == 0) || (w ? m0_err : m1_err) !== 1'b0) begin errors++; $display("FAIL rnd_err%0d got m0=%b m1=%b want %b", n, m0_err, m1_err, (es == 0)); end
      pend[w] = 1'b0;
      last_m = w;
      m0_req = pend[0]; m1_req = pend[1];
      @(negedge clk);
    end
    m0_req = 0; m1_req = 0;
  endtask
  initial begin
    test_reset();
    test_single_read();
    test_tie();
    test_write();
    test_errors();
    test_reset_mid();
    test_irq();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
